alu_rr_scheduler: RTL and testbench
===================================

Name: alu_rr_scheduler

Overview:
- Shares one 16-bit combinational ALU between NREQ requesters using a round-robin policy.
- Each requester presents a transaction of opcode, rs1 and rs2 on a valid/ready handshake.
- The scheduler grants one requester, registers its operands, drives the ALU for one cycle, and returns the registered result, flags and requester id on a valid/ready response port.
- It sits between the decode/issue logic and the shared ALU.

Parameters:
- WIDTH, 16, operand/result width in bits.
- NREQ, 4, number of requesters; must be >= 2.
- IDW, $clog2(NREQ), width of the requester id; derived, never overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester transaction valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high (one-hot or zero).
- req_op  in  4*NREQ  opcode of requester i at bits [4i+3:4i].
- req_rs1  in  WIDTH*NREQ  operand 1 of requester i at bits [WIDTH*i+WIDTH-1:WIDTH*i].
- req_rs2  in  WIDTH*NREQ  operand 2, same packing as req_rs1.
- alu_en  out  1  high while the ALU is evaluating the issued transaction.
- alu_op  out  4  opcode to ALU.
- alu_rs1  out  WIDTH  operand 1 to ALU.
- alu_rs2  out  WIDTH  operand 2 to ALU.
- alu_rd  in  WIDTH  ALU result; valid in the same cycle the operands are driven.
- alu_flag  in  3  ALU flags; bit 2 = illegal opcode.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  index of the requester the response belongs to.
- rsp_rd  out  WIDTH  registered result.
- rsp_flag  out  3  registered flags.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- State machine states: IDLE, EXEC, RESP.
- Reset (asynchronous, any time):
  - State goes to IDLE. An in-flight transaction is dropped and no response is produced.
  - rsp_valid, rsp_id, rsp_rd, rsp_flag, alu_en, busy, alu_op, alu_rs1, alu_rs2 reset to 0; req_ready reads 0.
  - Round-robin pointer last resets to NREQ-1, so requester 0 has top priority after reset.
- IDLE:
  - req_ready is combinational: one-hot at the winner when any req_valid is high, else 0.
  - Winner = first i with req_valid[i]=1, searching (last+1) mod NREQ upward with wrap-around.
  - On the handshake edge: capture the winner's op/rs1/rs2 into the issue register, the winner index into id, set last to the winner, go to EXEC.
  - No request pending: stay in IDLE; the pointer is unchanged.
- EXEC (exactly 1 cycle):
  - alu_en=1; alu_op/alu_rs1/alu_rs2 driven from the issue register.
  - At the edge: rsp_rd<=alu_rd, rsp_flag<=alu_flag, rsp_id<=id, rsp_valid<=1, go to RESP.
- RESP:
  - rsp_* held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid & rsp_ready: rsp_valid<=0, go to IDLE.
  - req_ready is 0 in EXEC and RESP.
- Issue register: holds its value outside EXEC, so alu_* stay quiet between transactions.
- Latency and throughput:
  - Request handshake to rsp_valid = 2 cycles.
  - Best-case throughput = 1 transaction per 3 cycles.
- Illegal opcodes (0, 13–15) are issued normally; the ALU flag is forwarded unchanged. The scheduler does not reject them.
- A requester holding req_valid high across its own grant is served again only after all other pending requesters.
- Requesters must hold payload stable while req_valid=1 and not granted.
- rsp_ready asserted with rsp_valid=0 has no effect.

Optional Feature:
- Macro: ALU_SCHED_STATS_EN.
- Defined: adds outputs stat_issued (16 bits) and stat_illegal (16 bits).
  - stat_issued increments on each EXEC cycle.
  - stat_illegal increments on each EXEC cycle where alu_flag[2]=1.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Single request: req_valid=4'b0001, op=ADD(4'b0001), rs1=100, rs2=23, rsp_ready=1.
   -> req_ready=4'b0001 in cycle 0; alu_en=1 in cycle 1; rsp_valid=1 in cycle 2 with rsp_rd=123, rsp_id=0; back in IDLE in cycle 3.
2. All four requesters valid continuously, rsp_ready=1.
   -> Grant order 0,1,2,3,0,…; 8 responses with rsp_id sequence 0,1,2,3,0,1,2,3.
3. Backpressure: one SUB, rs1=5, rs2=7; hold rsp_ready=0 for 5 cycles.
   -> rsp_valid stays 1 with rsp_rd=16'hFFFE stable; req_ready=0 throughout; release on rsp_ready=1.
4. Illegal op 4'b1111 from requester 2 (ALU returns flag[2]=1).
   -> rsp_flag[2]=1, rsp_id=2; with ALU_SCHED_STATS_EN, stat_illegal=1 and stat_issued=1.
5. Assert resetn=0 asynchronously while in EXEC.
   -> All outputs 0 immediately, no response emitted; after release, requester 0 wins first if req_valid=4'b1111.
6. Pointer wrap: last grant = 3, next req_valid=4'b1001.
   -> Requester 0 granted before requester 3.

Source files
------------

// File: rtl/alu_rr_scheduler.sv
// ============================================================================
// Module   : alu_rr_scheduler
// Purpose  : Round-robin arbiter sharing one combinational ALU among NREQ
//            requesters; optional stats counters under ALU_SCHED_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_rr_scheduler #(
  parameter  int WIDTH = 16,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [4*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_rs1,
  input  logic [WIDTH*NREQ-1:0] req_rs2,
  output logic                  alu_en,
  output logic [3:0]            alu_op,
  output logic [WIDTH-1:0]      alu_rs1,
  output logic [WIDTH-1:0]      alu_rs2,
  input  logic [WIDTH-1:0]      alu_rd,
  input  logic [2:0]            alu_flag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_rd,
  output logic [2:0]            rsp_flag,
`ifdef ALU_SCHED_STATS_EN
  output logic [15:0]           stat_issued,
  output logic [15:0]           stat_illegal,
`endif
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [IDW-1:0]   last_q;
  logic [IDW-1:0]   id_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] rs1_q;
  logic [WIDTH-1:0] rs2_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_rd_q;
  logic [2:0]       rsp_flag_q;

  logic [3:0]       op_arr  [NREQ];
  logic [WIDTH-1:0] rs1_arr [NREQ];
  logic [WIDTH-1:0] rs2_arr [NREQ];

  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   cand;
  logic             accept;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign op_arr[gi]  = req_op[4*gi +: 4];
    assign rs1_arr[gi] = req_rs1[WIDTH*gi +: WIDTH];
    assign rs2_arr[gi] = req_rs2[WIDTH*gi +: WIDTH];
  end

  // Search starts just after the last winner, so a requester that keeps
  // req_valid high after its grant waits behind every other pending one.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_q) + k) % NREQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found && resetn) begin
          req_ready[win_idx] = 1'b1;
          accept             = 1'b1;
          state_d            = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_q      <= IDW'(NREQ - 1);
      id_q        <= '0;
      op_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_rd_q    <= '0;
      rsp_flag_q  <= '0;
    end else begin
      if (accept) begin
        op_q   <= op_arr[win_idx];
        rs1_q  <= rs1_arr[win_idx];
        rs2_q  <= rs2_arr[win_idx];
        id_q   <= win_idx;
        last_q <= win_idx;
      end
      if (state_q == ST_EXEC) begin
        rsp_rd_q    <= alu_rd;
        rsp_flag_q  <= alu_flag;
        rsp_id_q    <= id_q;
        rsp_valid_q <= 1'b1;
      end else if (state_q == ST_RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

`ifdef ALU_SCHED_STATS_EN
  logic [15:0] issued_q;
  logic [15:0] illegal_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      issued_q  <= '0;
      illegal_q <= '0;
    end else if (state_q == ST_EXEC) begin
      if (issued_q != 16'hFFFF) begin
        issued_q <= issued_q + 16'd1;
      end
      if (alu_flag[2] && illegal_q != 16'hFFFF) begin
        illegal_q <= illegal_q + 16'd1;
      end
    end
  end

  assign stat_issued  = issued_q;
  assign stat_illegal = illegal_q;
`endif

  // Operands come straight from the issue register; it only changes on a
  // grant, so the ALU inputs stay quiet between transactions.
  assign alu_en    = (state_q == ST_EXEC);
  assign alu_op    = op_q;
  assign alu_rs1   = rs1_q;
  assign alu_rs2   = rs2_q;
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_flag  = rsp_flag_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_rr_scheduler.sv
// ============================================================================
// Module   : tb_alu_rr_scheduler
// Purpose  : Directed + random bench for alu_rr_scheduler with a reference ALU
//            and transaction model; stats checked when ALU_SCHED_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_rr_scheduler;
  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  resetn = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [4*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_rs1;
  logic [WIDTH*NREQ-1:0] req_rs2;
  logic                  alu_en;
  logic [3:0]            alu_op;
  logic [WIDTH-1:0]      alu_rs1;
  logic [WIDTH-1:0]      alu_rs2;
  logic [WIDTH-1:0]      alu_rd;
  logic [2:0]            alu_flag;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_rd;
  logic [2:0]            rsp_flag;
  logic                  busy;
`ifdef ALU_SCHED_STATS_EN
  logic [15:0]           stat_issued;
  logic [15:0]           stat_illegal;
`endif

  alu_rr_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .alu_en    (alu_en),
    .alu_op    (alu_op),
    .alu_rs1   (alu_rs1),
    .alu_rs2   (alu_rs2),
    .alu_rd    (alu_rd),
    .alu_flag  (alu_flag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_rd    (rsp_rd),
    .rsp_flag  (rsp_flag),
`ifdef ALU_SCHED_STATS_EN
    .stat_issued  (stat_issued),
    .stat_illegal (stat_illegal),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Environment ALU: {flag, rd}; flag = {illegal, negative, zero}.
  function automatic logic [18:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [15:0] r;
    logic        ill;
    r   = '0;
    ill = 1'b0;
    case (op)
      4'd1:    r = a + b;
      4'd2:    r = a - b;
      4'd3:    r = a & b;
      4'd4:    r = a | b;
      4'd5:    r = a ^ b;
      4'd6:    r = a << b[3:0];
      4'd7:    r = a >> b[3:0];
      4'd8:    r = 16'($signed(a) >>> b[3:0]);
      4'd9:    r = {15'd0, $signed(a) < $signed(b)};
      4'd10:   r = {15'd0, a < b};
      4'd11:   r = a;
      4'd12:   r = ~a;
      default: ill = 1'b1;
    endcase
    return {ill, r[15], r == 16'd0, r};
  endfunction

  always_comb {alu_flag, alu_rd} = alu_fn(alu_op, alu_rs1, alu_rs2);

  logic [3:0]       p_op  [NREQ];
  logic [WIDTH-1:0] p_rs1 [NREQ];
  logic [WIDTH-1:0] p_rs2 [NREQ];

  always_comb begin
    req_op  = '0;
    req_rs1 = '0;
    req_rs2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_op[4*i +: 4]          = p_op[i];
      req_rs1[WIDTH*i +: WIDTH] = p_rs1[i];
      req_rs2[WIDTH*i +: WIDTH] = p_rs2[i];
    end
  end

  int total = 0;
  int bad   = 0;
  int obs_ids[$];
  logic [NREQ-1:0] last_er = '0;

  // Transaction-level reference: phase 0 waiting, 1 on ALU, 2 response out.
  int          m_ph, m_last, m_id, m_rid, m_iss, m_ill;
  logic [3:0]  m_op;
  logic [15:0] m_rs1, m_rs2, m_rd;
  logic [2:0]  m_flag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_last = NREQ - 1; m_id = 0; m_rid = 0; m_iss = 0; m_ill = 0;
    m_op = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_flag = '0;
  endtask

  task automatic newp(input int i);
    p_op[i]  = 4'($urandom_range(0, 15));
    p_rs1[i] = 16'($urandom);
    p_rs2[i] = 16'($urandom);
  endtask

  task automatic cyc();
    logic [NREQ-1:0] er;
    int w;
    @(negedge clk);
    w  = pick(m_last, req_valid);
    er = '0;
    if (resetn && m_ph == 0 && w >= 0) er[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("alu_en",    32'(alu_en),    32'(m_ph == 1));
    chk("alu_op",    32'(alu_op),    32'(m_op));
    chk("alu_rs1",   32'(alu_rs1),   32'(m_rs1));
    chk("alu_rs2",   32'(alu_rs2),   32'(m_rs2));
    chk("busy",      32'(busy),      32'(m_ph != 0));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_ph == 2));
    chk("rsp_id",    32'(rsp_id),    32'(m_rid));
    chk("rsp_rd",    32'(rsp_rd),    32'(m_rd));
    chk("rsp_flag",  32'(rsp_flag),  32'(m_flag));
`ifdef ALU_SCHED_STATS_EN
    chk("stat_issued",  32'(stat_issued),  32'(m_iss));
    chk("stat_illegal", 32'(stat_illegal), 32'(m_ill));
`endif
    if (rsp_valid === 1'b1 && rsp_ready) obs_ids.push_back(int'(rsp_id));
    last_er = er;
    @(posedge clk);
    if (!resetn) begin
      model_reset();
    end else begin
      case (m_ph)
        0: if (w >= 0) begin
          m_op = p_op[w]; m_rs1 = p_rs1[w]; m_rs2 = p_rs2[w];
          m_id = w; m_last = w; m_ph = 1;
        end
        1: begin
          {m_flag, m_rd} = alu_fn(m_op, m_rs1, m_rs2);
          m_rid = m_id;
          m_ph  = 2;
          if (m_iss < 16'hFFFF) m_iss++;
          if (m_flag[2] && m_ill < 16'hFFFF) m_ill++;
        end
        default: if (rsp_ready) m_ph = 0;
      endcase
    end
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    cyc();
    cyc();
    resetn = 1'b1;
  endtask

  initial begin
    int n;
    for (int i = 0; i < NREQ; i++) newp(i);
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Single ADD from requester 0
    p_op[0] = 4'd1; p_rs1[0] = 16'd100; p_rs2[0] = 16'd23;
    req_valid = 4'b0001; rsp_ready = 1'b1;
    #1 chk("t1_ready", 32'(req_ready), 32'h1);
    cyc();
    req_valid = '0;
    #1 chk("t1_alu_en", 32'(alu_en), 32'h1);
    chk("t1_alu_op", 32'(alu_op), 32'h1);
    cyc();
    #1 chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_rd", 32'(rsp_rd), 32'd123);
    chk("t1_rsp_id", 32'(rsp_id), 32'd0);
    cyc();
    #1 chk("t1_idle", 32'(busy), 32'h0);

    // All four continuously valid: ids must rotate 0..3 twice
    do_reset();
    obs_ids.delete();
    req_valid = 4'b1111; rsp_ready = 1'b1;
    n = 0;
    while (obs_ids.size() < 8 && n < 60) begin
      cyc();
      for (int i = 0; i < NREQ; i++) if (last_er[i]) newp(i);
      n++;
    end
    chk("t2_count", 32'(obs_ids.size()), 32'd8);
    for (int i = 0; i < obs_ids.size() && i < 8; i++) chk("t2_id", 32'(obs_ids[i]), 32'(i % 4));
    req_valid = '0;
    repeat (4) cyc();

    // Backpressure on a SUB result
    p_op[1] = 4'd2; p_rs1[1] = 16'd5; p_rs2[1] = 16'd7;
    req_valid = 4'b0010; rsp_ready = 1'b0;
    cyc();
    req_valid = '0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      req_valid = 4'b0101;
      #1 chk("t3_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t3_rsp_rd", 32'(rsp_rd), 32'hFFFE);
      chk("t3_req_ready", 32'(req_ready), 32'h0);
      cyc();
    end
    req_valid = '0; rsp_ready = 1'b1;
    repeat (3) cyc();

    // Illegal opcode from requester 2
    do_reset();
    p_op[2] = 4'hF;
    req_valid = 4'b0100; rsp_ready = 1'b1;
    cyc();
    req_valid = '0;
    cyc();
    #1 chk("t4_flag2", 32'(rsp_flag[2]), 32'h1);
    chk("t4_rsp_id", 32'(rsp_id), 32'd2);
`ifdef ALU_SCHED_STATS_EN
    chk("t4_issued", 32'(stat_issued), 32'd1);
    chk("t4_illegal", 32'(stat_illegal), 32'd1);
`endif
    cyc();

    // Asynchronous reset in the middle of EXEC
    p_op[0] = 4'd1;
    req_valid = 4'b0001;
    cyc();
    req_valid = 4'b1111;
    #2 resetn = 1'b0;
    model_reset();
    #1 chk("t5_alu_en", 32'(alu_en), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_req_ready", 32'(req_ready), 32'h0);
    chk("t5_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("t5_alu_op", 32'(alu_op), 32'h0);
    chk("t5_alu_rs1", 32'(alu_rs1), 32'h0);
    cyc();
    resetn = 1'b1;
    #1 chk("t5_first", 32'(req_ready), 32'h1);
    cyc();
    req_valid = '0;
    repeat (3) cyc();

    // Pointer wrap: after granting 3, requester 0 beats 3
    req_valid = 4'b1000;
    cyc();
    req_valid = '0;
    cyc();
    cyc();
    req_valid = 4'b1001;
    #1 chk("t6_wrap", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 4'b1000;
    cyc();
    cyc();
    #1 chk("t6_next", 32'(req_ready), 32'h8);
    cyc();
    req_valid = '0;
    repeat (3) cyc();

    // Random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      cyc();
      for (int i = 0; i < NREQ; i++) begin
        if (last_er[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          newp(i);
        end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          newp(i);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
